uart_tx_arbiter: RTL
====================

// Module: uart_tx_arbiter
// PURPOSE
// Shares one uart_tx transmitter between NUM_REQ byte-stream requesters.
// Grants use round-robin order and are packet-locked: a grant is held from the first byte to the byte flagged req_last.
// Sequences the single-cycle tx_valid/tx_ready handshake of uart_tx and drives its parity_mode per packet.
// Sits between host-side producers and uart_tx; uart_rx is unaffected.
// PARAMETERS
// NUM_REQ         4   number of requesters (>=2)
// DATA_BITS       8   byte width; matches uart_tx DATA_BITS
// ACCEPT_TIMEOUT  4   cycles allowed for tx_ready to fall after a tx_valid pulse
// PORTS
// clk           in   1                   system clock
// rst_n         in   1                   asynchronous active-low reset
// req_valid     in   NUM_REQ             per-requester byte available
// req_data      in   NUM_REQ*DATA_BITS   requester i byte at [i*DATA_BITS +: DATA_BITS]
// req_last      in   NUM_REQ             byte is the last of its packet
// req_parity    in   2*NUM_REQ           requester i parity mode at [2i +: 2]; sampled at grant
// req_ready     out  NUM_REQ             byte consumed this cycle (one-hot or zero)
// tx_data       out  DATA_BITS           to uart_tx tx_data
// tx_valid      out  1                   to uart_tx tx_valid; one-cycle pulse
// tx_ready      in   1                   from uart_tx tx_ready
// parity_mode   out  2                   to uart_tx parity_mode; constant for a whole packet
// grant_id      out  $clog2(NUM_REQ)     current/last granted requester
// grant_active  out  1                   a packet is in progress
// accept_err    out  1                   one-cycle pulse: tx_ready did not fall within ACCEPT_TIMEOUT
// BEHAVIOUR
// Reset values: all outputs 0, state IDLE, RR pointer 0, internal last flag 0.
// FSM states: IDLE, LOAD, ISSUE, WAIT_BUSY, WAIT_DONE.
// - IDLE: when any req_valid is set, the winner is the first set bit at or after the RR pointer, with wrap-around.
//   Next edge: latch grant_id, latch parity_mode <= req_parity[winner], set grant_active=1, go to LOAD.
// - LOAD: when tx_ready=1 and req_valid[g]=1, drive req_ready[g]=1 combinationally.
//   Next edge: tx_data <= req_data[g], tx_valid <= 1, latch req_last[g], go to ISSUE.
//   Otherwise stay in LOAD and hold the grant; no timeout applies to a stalled requester.
// - ISSUE: tx_valid is high for exactly this cycle. Next edge: tx_valid <= 0, go to WAIT_BUSY.
// - WAIT_BUSY: wait for tx_ready=0, then go to WAIT_DONE.
//   A counter runs here; after ACCEPT_TIMEOUT cycles with no fall, pulse accept_err and go to WAIT_DONE.
// - WAIT_DONE: wait for tx_ready=1.
//   If the latched last flag is 0, go to LOAD.
//   If it is 1: grant_active <= 0, RR pointer <= (g+1) mod NUM_REQ, go to IDLE.
// Latency: req_valid seen in IDLE at cycle k -> req_ready at k+1 -> tx_valid at k+2.
// Rules:
// - At most one req_ready bit is set per cycle.
// - req_ready is only ever asserted in LOAD.
// - tx_data and parity_mode are stable while tx_valid=1 and for the whole packet.
// Simultaneous requests are resolved by the RR pointer only. A requester that wins is lowest priority next time.
// req_parity changes mid-packet are ignored until the next grant.
// Reset asserted mid-frame: return to IDLE at once with all outputs 0.
//   The partial packet is dropped; requesters resend after reset.
// STRUCTURE
// uart_pkg: parity_mode encoding constants (shared with uart_tx and uart_rx), and the FSM state enum.
// Sub-module rr_arbiter: combinational one-hot round-robin pick from (req vector, pointer).
// The top level holds the FSM, the pointer, the timeout counter and the output registers.
// TESTING
// Common setup: bench at CLK_FREQ=1_000_000, BAUD_RATE=10_000; DUT drives uart_tx, looped back into uart_rx.
// 1 Single byte: req0 sends 0xA5 (last=1, parity none)
//   -> uart_rx gets 0xA5 with no error; grant_id=0; grant_active falls after the stop bit.
// 2 Contention: req0-req3 each send a 2-byte packet ({0x10,0x11}..{0x40,0x41}), all raised in the same cycle
//   -> rx order is 10,11,20,21,30,31,40,41; no interleaving between packets.
// 3 Fairness: req0 requests continuously while req2 sends one packet
//   -> req2's packet starts immediately after req0's current packet ends.
// 4 Parity lock: req1 packet {0x3C,0xC3} with even parity; req_parity[1] flipped to odd between the two bytes
//   -> both bytes go out with even parity; uart_rx reports no error.
// 5 Stall and timeout: req0 drops req_valid mid-packet for 30 cycles -> grant is held and no other requester is served.
//   Separately, tie tx_ready high -> accept_err pulses ACCEPT_TIMEOUT+1 cycles after ISSUE.
// 6 Reset mid-frame: assert rst_n=0 at bit 4 of 0x5A
//   -> all outputs are 0 next cycle; after release, req3 sending 0x77 is received correctly.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: parity encodings used by
// uart_tx/uart_rx, the arbiter FSM state type and a round-robin index helper.
package uart_tx_arbiter_pkg;

    localparam logic [1:0] PARITY_NONE = 2'b00;
    localparam logic [1:0] PARITY_EVEN = 2'b01;
    localparam logic [1:0] PARITY_ODD  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_ISSUE     = 3'd2,
        ST_WAIT_BUSY = 3'd3,
        ST_WAIT_DONE = 3'd4
    } arb_state_e;

    function automatic int unsigned wrap_idx(input int unsigned base,
                                             input int unsigned off,
                                             input int unsigned n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping,
// returned both one-hot and as an index.
module uart_tx_arbiter_rr_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IW-1:0]      gnt_idx
);

    logic          found;
    logic [IW-1:0] idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = '0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            idx = IW'(wrap_idx(32'(ptr), off, NUM_REQ));
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter sharing one uart_tx between NUM_REQ
// byte-stream producers; sequences the tx_valid/tx_ready handshake.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_IDLE      | no packet in progress; pick winner from RR pointer
// ST_LOAD      | grant held; wait for tx_ready and the granted req_valid
// ST_ISSUE     | tx_valid high for this single cycle
// ST_WAIT_BUSY | wait for tx_ready to fall; bounded by ACCEPT_TIMEOUT
// ST_WAIT_DONE | wait for tx_ready to rise; next byte or release grant
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int DATA_BITS      = 8,
    parameter int ACCEPT_TIMEOUT = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_BITS-1:0]  req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [2*NUM_REQ-1:0]          req_parity,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_BITS-1:0]          tx_data,
    output logic                          tx_valid,
    input  logic                          tx_ready,
    output logic [1:0]                    parity_mode,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          grant_active,
    output logic                          accept_err
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = (ACCEPT_TIMEOUT < 2) ? 1 : $clog2(ACCEPT_TIMEOUT);

    arb_state_e             state_q, state_d;
    logic [IW-1:0]          rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]          grant_id_q, grant_id_d;
    logic                   grant_active_q, grant_active_d;
    logic [1:0]             parity_mode_q, parity_mode_d;
    logic [DATA_BITS-1:0]   tx_data_q, tx_data_d;
    logic                   tx_valid_q, tx_valid_d;
    logic                   last_q, last_d;
    logic [CW-1:0]          tmo_cnt_q, tmo_cnt_d;
    logic                   accept_err_q, accept_err_d;
    logic [NUM_REQ-1:0]     req_ready_c;

    logic [NUM_REQ-1:0]     win_gnt;
    logic [IW-1:0]          win_idx;

    uart_tx_arbiter_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_rr (
        .req     (req_valid),
        .ptr     (rr_ptr_q),
        .gnt     (win_gnt),
        .gnt_idx (win_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            rr_ptr_q       <= '0;
            grant_id_q     <= '0;
            grant_active_q <= 1'b0;
            parity_mode_q  <= '0;
            tx_data_q      <= '0;
            tx_valid_q     <= 1'b0;
            last_q         <= 1'b0;
            tmo_cnt_q      <= '0;
            accept_err_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            grant_id_q     <= grant_id_d;
            grant_active_q <= grant_active_d;
            parity_mode_q  <= parity_mode_d;
            tx_data_q      <= tx_data_d;
            tx_valid_q     <= tx_valid_d;
            last_q         <= last_d;
            tmo_cnt_q      <= tmo_cnt_d;
            accept_err_q   <= accept_err_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        grant_id_d     = grant_id_q;
        grant_active_d = grant_active_q;
        parity_mode_d  = parity_mode_q;
        tx_data_d      = tx_data_q;
        tx_valid_d     = 1'b0;
        last_d         = last_q;
        tmo_cnt_d      = tmo_cnt_q;
        accept_err_d   = 1'b0;
        req_ready_c    = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (|win_gnt) begin
                    grant_id_d     = win_idx;
                    parity_mode_d  = req_parity[win_idx*2 +: 2];
                    grant_active_d = 1'b1;
                    state_d        = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // A stalled requester keeps the grant indefinitely.
                if (tx_ready && req_valid[grant_id_q]) begin
                    req_ready_c[grant_id_q] = 1'b1;
                    tx_data_d  = req_data[grant_id_q*DATA_BITS +: DATA_BITS];
                    tx_valid_d = 1'b1;
                    last_d     = req_last[grant_id_q];
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                tmo_cnt_d = CW'(ACCEPT_TIMEOUT - 1);
                state_d   = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (!tx_ready) begin
                    state_d = ST_WAIT_DONE;
                end else if (tmo_cnt_q == '0) begin
                    accept_err_d = 1'b1;
                    state_d      = ST_WAIT_DONE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q - 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (tx_ready) begin
                    if (last_q) begin
                        grant_active_d = 1'b0;
                        rr_ptr_d       = IW'(wrap_idx(32'(grant_id_q), 1, NUM_REQ));
                        state_d        = ST_IDLE;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign req_ready    = req_ready_c;
    assign tx_data      = tx_data_q;
    assign tx_valid     = tx_valid_q;
    assign parity_mode  = parity_mode_q;
    assign grant_id     = grant_id_q;
    assign grant_active = grant_active_q;
    assign accept_err   = accept_err_q;

endmodule
